nway_join_dut: RTL
==================

// Module: nway_join_dut
// PURPOSE
//  Parametrised N-input join: buffers each input stream in its own FIFO, combines
//  one word from every input with a runtime-selected op (XOR/AND/OR/ADD), and issues
//  the result on a registered en/rdy output. Next-generation two-input join for the
//  handshake test DUT family. Operands are captured at acceptance, not at combine time.
// PARAMETERS
//  NUM_IN  2   number of input channels (2..8)
//  WIDTH   1   data width per channel and of result (1..32)
//  DEPTH   4   per-input FIFO depth, power of two (2..16)
// PORTS
//  clk        in   1              rising-edge clock
//  reset      in   1              asynchronous, active-high reset
//  in_data    in   NUM_IN*WIDTH   channel i at [i*WIDTH +: WIDTH]
//  in_en      in   NUM_IN         channel i offers a word
//  in_rdy     out  NUM_IN         channel i FIFO not full
//  op_sel     in   2              00 XOR, 01 AND, 10 OR, 11 ADD; sampled on fire
//  y_data     out  WIDTH          result (registered)
//  y_en       out  1              result valid
//  y_rdy      in   1              downstream accepts result
//  res_cnt    out  16             count of results consumed (y_en&&y_rdy), wraps
// BEHAVIOUR
//  - Reset (any time, async): all FIFOs empty, y_en=0, y_data=0, res_cnt=0,
//    in_rdy=all ones after reset deasserts. In-flight words are discarded.
//  - Input accept: in_en[i] && in_rdy[i] at posedge -> in_data slice pushed to FIFO i.
//    in_rdy[i] = (count[i] != DEPTH), derived from registered state only; no
//    combinational path from in_en, y_rdy, or op_sel.
//  - Fire condition: every FIFO non-empty AND (y_en==0 || y_rdy==1).
//    On fire: pop one word from every FIFO; y_data <= reduce(op_sel, heads); y_en <= 1.
//  - Output consume without fire: y_en && y_rdy && !fire -> y_en <= 0, y_data holds.
//  - y_en high and y_rdy low: y_data and y_en hold; FIFOs keep filling until full.
//  - Reduce: XOR/AND/OR bitwise across all NUM_IN heads; ADD sums all heads,
//    truncated modulo 2^WIDTH with no carry-out.
//  - Latency: a word accepted at edge k can fire at edge k+1 at the earliest
//    (y_en visible after k+1). Throughput is 1 result/clk while y_rdy=1.
//  - Simultaneous push and pop on the same FIFO: count unchanged, both take effect.
//    A push to a full FIFO cannot occur because in_rdy=0.
//  - FIFO pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.
//  - res_cnt increments on each y_en && y_rdy and wraps 0xFFFF -> 0x0000.
//  - op_sel changes take effect only at the next fire; a held result is unaffected.
// STRUCTURE
//  - Shared package: op_sel encodings (OP_XOR=2'b00, OP_AND, OP_OR, OP_ADD), the
//    clog2 helper.
//  - Sub-module join_fifo: WIDTH x DEPTH sync FIFO with push, pop, head, empty, full,
//    and count, using async active-high reset. Instantiate it NUM_IN times via generate.
//  - Top level: fire logic, reduce function, output register, res_cnt.
// TESTING
//  1. NUM_IN=2, WIDTH=1, op XOR: a=1, b=1, y_rdy=1 -> y_data=0, y_en for 1 clk, res_cnt=1.
//  2. NUM_IN=3, WIDTH=8, ADD: ch0=0xF0, ch1=0x20, ch2=0x01 -> y_data=0x11 (wrap).
//  3. y_rdy=0. Push DEPTH+1 words on ch0 only -> in_rdy[0]=0 after DEPTH pushes,
//     y_en stays 0, and the extra word is not accepted.
//  4. Back-to-back streaming with all en=1 and y_rdy=1, 8 words, XOR -> 8 results
//     on consecutive clocks in order, res_cnt=8.
//  5. Output stall: y_en=1 and y_rdy=0 for 3 clks -> y_data stable.
//     Then y_rdy=1 -> the next result follows on the next clock.
//  6. Assert reset mid-stream with FIFOs partly full and y_en=1 -> y_en=0, y_data=0,
//     res_cnt=0 immediately. Post-reset results use only new inputs.

Source files
------------

// File: rtl/nway_join_pkg.sv
// Shared definitions for the N-way join: combine-op encodings and a
// constant-foldable log2 helper used to size FIFO pointers and counts.
package nway_join_pkg;

  typedef enum logic [1:0] {
    OP_XOR = 2'b00,
    OP_AND = 2'b01,
    OP_OR  = 2'b10,
    OP_ADD = 2'b11
  } op_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/nway_join_fifo.sv
// Per-channel synchronous FIFO for the N-way join. Caller guarantees no push
// when full and no pop when empty; pointers wrap naturally at DEPTH.
module join_fifo
  import nway_join_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_push,
  input  logic [WIDTH-1:0]      i_data,
  input  logic                  i_pop,
  output logic [WIDTH-1:0]      o_head,
  output logic                  o_empty,
  output logic                  o_full,
  output logic [clog2(DEPTH):0] o_count
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [AW:0]      r_count;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wrPtr] <= i_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wrPtr <= r_wrPtr + PTR_ONE;
      if (i_pop)  r_rdPtr <= r_rdPtr + PTR_ONE;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rdPtr];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_FULL);
  assign o_count = r_count;

endmodule

// File: rtl/nway_join_dut.sv
// N-input join: one FIFO per channel, fires when every FIFO holds a word and
// the output slot is free, reducing the heads with the op selected at fire time.
module nway_join_dut
  import nway_join_pkg::*;
#(
  parameter int NUM_IN = 2,
  parameter int WIDTH  = 1,
  parameter int DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_en,
  output logic [NUM_IN-1:0]       in_rdy,
  input  logic [1:0]              op_sel,
  output logic [WIDTH-1:0]        y_data,
  output logic                    y_en,
  input  logic                    y_rdy,
  output logic [15:0]             res_cnt
);

  localparam int CW = clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [NUM_IN-1:0]       w_push;
  logic [NUM_IN-1:0]       w_empty;
  logic [NUM_IN-1:0]       w_full;
  logic [NUM_IN*WIDTH-1:0] w_heads;
  logic                    w_fire;
  logic [WIDTH-1:0]        w_result;

  logic                    r_yEn;
  logic [WIDTH-1:0]        r_yData;
  logic [15:0]             r_resCnt;

  for (genvar g = 0; g < NUM_IN; g++) begin : g_ch
    logic [CW-1:0] w_count;

    // Ready comes from the registered count only, so no input-to-ready path exists.
    assign in_rdy[g] = (w_count != CNT_FULL);
    assign w_push[g] = in_en[g] & ~w_full[g];

    join_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push[g]),
      .i_data  (in_data[g*WIDTH +: WIDTH]),
      .i_pop   (w_fire),
      .o_head  (w_heads[g*WIDTH +: WIDTH]),
      .o_empty (w_empty[g]),
      .o_full  (w_full[g]),
      .o_count (w_count)
    );
  end

  function automatic logic [WIDTH-1:0] reduceHeads(input logic [1:0] op,
                                                   input logic [NUM_IN*WIDTH-1:0] heads);
    logic [WIDTH-1:0] acc;
    acc = heads[WIDTH-1:0];
    for (int i = 1; i < NUM_IN; i++) begin
      case (op)
        OP_XOR:  acc = acc ^ heads[i*WIDTH +: WIDTH];
        OP_AND:  acc = acc & heads[i*WIDTH +: WIDTH];
        OP_OR:   acc = acc | heads[i*WIDTH +: WIDTH];
        default: acc = acc + heads[i*WIDTH +: WIDTH];
      endcase
    end
    return acc;
  endfunction

  assign w_fire   = (&(~w_empty)) && (!r_yEn || y_rdy);
  assign w_result = reduceHeads(op_sel, w_heads);

  // A fire both refills and keeps y_en high; a consume without fire just drains it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_yEn    <= 1'b0;
      r_yData  <= '0;
      r_resCnt <= '0;
    end else begin
      if (w_fire) begin
        r_yData <= w_result;
        r_yEn   <= 1'b1;
      end else if (r_yEn && y_rdy) begin
        r_yEn   <= 1'b0;
      end
      if (r_yEn && y_rdy) r_resCnt <= r_resCnt + 16'd1;
    end
  end

  assign y_data  = r_yData;
  assign y_en    = r_yEn;
  assign res_cnt = r_resCnt;

endmodule
